// File: rtl/lcd_pkg.sv
// Shared mode codes and default dot/line timing for the LCD mode sequencer.
package lcd_pkg;

  localparam logic [1:0] MODE_HBLANK = 2'b00;
  localparam logic [1:0] MODE_VBLANK = 2'b01;
  localparam logic [1:0] MODE_OAM    = 2'b10;
  localparam logic [1:0] MODE_XFER   = 2'b11;

  localparam int unsigned LCD_DOTS_PER_LINE = 456;
  localparam int unsigned LCD_LINES         = 154;
  localparam int unsigned LCD_VIS_LINES     = 144;
  localparam int unsigned LCD_OAM_DOTS      = 80;
  localparam int unsigned LCD_PIX_PER_LINE  = 160;
  localparam int unsigned LCD_M3_MAX_END    = 376;

endpackage

// File: rtl/lcd_stat_irq.sv
// STAT interrupt line and its rising-edge pulse; overlapping sources never retrigger.
module lcd_stat_irq
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       running,
  input  logic [1:0] mode,
  input  logic       lyc_match,
  input  logic [3:0] stat_en,
  output logic       irq_stat
);

  logic stat_line;
  logic stat_d;

  always_comb begin
    stat_d = running & ((stat_en[0] & (mode == MODE_HBLANK)) |
                        (stat_en[1] & (mode == MODE_VBLANK)) |
                        (stat_en[2] & (mode == MODE_OAM))    |
                        (stat_en[3] & lyc_match));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_line <= 1'b0;
      irq_stat  <= 1'b0;
    end else begin
      stat_line <= stat_d;
      irq_stat  <= stat_d & ~stat_line;
    end
  end

endmodule

// File: rtl/lcd_mode_seq.sv
// Dot/line counters and PPU mode FSM; gates fetcher pixel pushes during mode 11.
module lcd_mode_seq
  import lcd_pkg::*;
#(
  parameter int unsigned DOTS_PER_LINE = LCD_DOTS_PER_LINE,
  parameter int unsigned LINES         = LCD_LINES,
  parameter int unsigned VIS_LINES     = LCD_VIS_LINES,
  parameter int unsigned OAM_DOTS      = LCD_OAM_DOTS,
  parameter int unsigned PIX_PER_LINE  = LCD_PIX_PER_LINE,
  parameter int unsigned M3_MAX_END    = LCD_M3_MAX_END
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       lcd_on,
  input  logic [7:0] lyc,
  input  logic [3:0] stat_en,
  input  logic       pix_valid,
  output logic       pix_push,
  output logic [1:0] mode,
  output logic [7:0] ly,
  output logic [8:0] dot,
  output logic       lyc_match,
  output logic       line_start,
  output logic       irq_vblank,
  output logic       irq_stat
);

  localparam logic [8:0] DotLast  = 9'(DOTS_PER_LINE - 1);
  localparam logic [8:0] DotOam   = 9'(OAM_DOTS);
  localparam logic [8:0] DotM3End = 9'(M3_MAX_END);
  localparam logic [7:0] LyLast   = 8'(LINES - 1);
  localparam logic [7:0] LyVis    = 8'(VIS_LINES);
  localparam logic [7:0] PixMax   = 8'(PIX_PER_LINE);

  logic       running;
  logic [7:0] px_cnt;
  logic       wrap;
  logic [8:0] dot_n;
  logic [7:0] ly_n;
  logic [7:0] px_n;
  logic [1:0] mode_n;
  logic       stat_run;

  // Gated by lcd_on/reset so nothing is pushed on the edge the LCD turns off.
  assign pix_push = ce & running & lcd_on & ~reset & (mode == MODE_XFER) &
                    pix_valid & (px_cnt < PixMax);

  always_comb begin
    wrap   = (dot == DotLast);
    dot_n  = wrap ? 9'd0 : dot + 9'd1;
    ly_n   = ly;
    if (wrap) begin
      ly_n = (ly == LyLast) ? 8'd0 : ly + 8'd1;
    end
    px_n   = px_cnt + {7'd0, pix_push};
    mode_n = mode;
    if (ly_n >= LyVis) begin
      mode_n = MODE_VBLANK;
    end else if (dot_n < DotOam) begin
      mode_n = MODE_OAM;
    end else if (dot_n == DotOam) begin
      mode_n = MODE_XFER;
    end else if ((mode == MODE_XFER) && ((px_n == PixMax) || (dot_n == DotM3End))) begin
      mode_n = MODE_HBLANK;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !lcd_on) begin
      running    <= 1'b0;
      dot        <= 9'd0;
      ly         <= 8'd0;
      mode       <= MODE_HBLANK;
      px_cnt     <= 8'd0;
      lyc_match  <= 1'b0;
      line_start <= 1'b0;
      irq_vblank <= 1'b0;
    end else begin
      line_start <= 1'b0;
      irq_vblank <= 1'b0;
      lyc_match  <= (ly == lyc);
      if (ce) begin
        if (!running) begin
          running <= 1'b1;
          mode    <= MODE_OAM;
        end else begin
          dot        <= dot_n;
          ly         <= ly_n;
          mode       <= mode_n;
          px_cnt     <= (dot_n == DotOam) ? 8'd0 : px_n;
          line_start <= wrap;
          irq_vblank <= (mode_n == MODE_VBLANK) && (mode != MODE_VBLANK);
        end
      end
    end
  end

  assign stat_run = running & lcd_on & ~reset;

  lcd_stat_irq u_stat_irq (
    .clk       (clk),
    .reset     (reset),
    .running   (stat_run),
    .mode      (mode),
    .lyc_match (lyc_match),
    .stat_en   (stat_en),
    .irq_stat  (irq_stat)
  );

endmodule

// File: tb/tb_lcd_mode_seq.sv
// Directed bench for lcd_mode_seq: line timing, push gating, LYC/STAT irqs, frame, LCD off.
module tb_lcd_mode_seq;

  logic       clk = 1'b0;
  logic       reset, ce, lcd_on, pix_valid;
  logic [7:0] lyc;
  logic [3:0] stat_en;
  logic       pix_push, lyc_match, line_start, irq_vblank, irq_stat;
  logic [1:0] mode;
  logic [7:0] ly;
  logic [8:0] dot;

  int n_tests = 0;
  int n_fail  = 0;
  logic       push_seen;
  logic [1:0] mode_before;

  always #5 clk = ~clk;

  lcd_mode_seq dut (
    .clk        (clk),
    .reset      (reset),
    .ce         (ce),
    .lcd_on     (lcd_on),
    .lyc        (lyc),
    .stat_en    (stat_en),
    .pix_valid  (pix_valid),
    .pix_push   (pix_push),
    .mode       (mode),
    .ly         (ly),
    .dot        (dot),
    .lyc_match  (lyc_match),
    .line_start (line_start),
    .irq_vblank (irq_vblank),
    .irq_stat   (irq_stat)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // pix_push is combinational, so it is captured just before the edge.
  task automatic tick();
    #1;
    push_seen   = pix_push;
    mode_before = mode;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pc, vm, end_dot, lm_c, lm_ly, irq_c, st_n, found, extra;
    int ms[4];
    int ls_n, ls_first, ls_last, ls_bad, vb_n, vb_c, vb_ly, vb_dot, vb_mode;
    int ly_pre, mode_pre, ly_end, dot_end, mode_end, st_last;
    logic prev_lm;

    reset = 1'b1; ce = 1'b1; lcd_on = 1'b1; pix_valid = 1'b1;
    lyc = 8'd5; stat_en = 4'b1000;
    tick();
    tick();
    check("rst_mode", int'(mode), 0);
    check("rst_dot", int'(dot), 0);
    check("rst_ly", int'(ly), 0);
    check("rst_lyc_match", int'(lyc_match), 0);
    check("rst_push", int'(push_seen), 0);
    check("rst_pulses", int'({line_start, irq_vblank, irq_stat}), 0);

    // Phase 1: toggling pixels, LYC irq, then LCD off mid mode 11 at ly 60.
    reset = 1'b0; pix_valid = 1'b0;
    tick();
    check("start_mode", int'(mode), 2);
    check("start_dot", int'(dot), 0);
    pc = 0; vm = 0; end_dot = -1; lm_c = -1; lm_ly = -1; irq_c = -1; st_n = 0;
    found = 0; prev_lm = lyc_match;
    for (int c = 1; c <= 30000; c++) begin
      pix_valid = c[0];
      tick();
      if (c <= 455) begin
        if (push_seen) pc++;
        if (pix_valid && mode_before == 2'b11) vm++;
        if (mode_before == 2'b11 && mode == 2'b00) end_dot = int'(dot);
      end
      if (lyc_match && !prev_lm && lm_c < 0) begin
        lm_c = c; lm_ly = int'(ly);
      end
      prev_lm = lyc_match;
      if (irq_stat) begin
        st_n++;
        if (irq_c < 0) irq_c = c;
      end
      if (ly == 8'd60 && mode == 2'b11 && dot == 9'd150) begin
        found = 1;
        break;
      end
    end
    check("tog_xfer_end_dot", end_dot, 376);
    check("tog_push_cnt", pc, 148);
    check("tog_push_vs_valid", pc, vm);
    check("lyc_rise_ly", lm_ly, 5);
    check("lyc_irq_lag", irq_c - lm_c, 1);
    check("lyc_irq_count", st_n, 1);
    check("reach_ly60", found, 1);

    pix_valid = 1'b1; lcd_on = 1'b0;
    tick();
    check("off_push", int'(push_seen), 0);
    check("off_ly", int'(ly), 0);
    check("off_dot", int'(dot), 0);
    check("off_mode", int'(mode), 0);
    check("off_lyc_match", int'(lyc_match), 0);
    check("off_pulses", int'({line_start, irq_vblank, irq_stat}), 0);
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (push_seen || irq_stat || irq_vblank || mode != 2'b00) extra++;
    end
    check("off_hold_quiet", extra, 0);
    lcd_on = 1'b1; ce = 1'b0;
    tick();
    check("on_no_ce_mode", int'(mode), 0);
    ce = 1'b1;
    tick();
    check("reon_mode", int'(mode), 2);
    check("reon_dot", int'(dot), 0);

    // Phase 2: full frame with pix_valid high, hblank+oam STAT sources.
    reset = 1'b1;
    tick();
    reset = 1'b0; pix_valid = 1'b1; stat_en = 4'b0101; lyc = 8'd200;
    tick();
    ms = '{0, 0, 0, 0};
    ms[mode]++;
    ls_n = 0; ls_first = -1; ls_last = 0; ls_bad = 0;
    vb_n = 0; vb_c = -1; vb_ly = -1; vb_dot = -1; vb_mode = -1; st_n = 0;
    ly_pre = -1; mode_pre = -1; ly_end = -1; dot_end = -1; mode_end = -1; st_last = -1;
    for (int c = 1; c <= 70225; c++) begin
      tick();
      if (c <= 455) ms[mode]++;
      if (line_start) begin
        if (ls_n == 0) ls_first = c;
        else if (c - ls_last != 456) ls_bad++;
        ls_last = c;
        ls_n++;
      end
      if (irq_vblank) begin
        vb_n++; vb_c = c; vb_ly = int'(ly); vb_dot = int'(dot); vb_mode = int'(mode);
      end
      if (irq_stat && c <= 70224) st_n++;
      if (c == 70223) begin
        ly_pre = int'(ly); mode_pre = int'(mode);
      end
      if (c == 70224) begin
        ly_end = int'(ly); dot_end = int'(dot); mode_end = int'(mode);
      end
      if (c == 70225) st_last = int'(irq_stat);
    end
    check("line0_oam_dots", ms[2], 80);
    check("line0_xfer_dots", ms[3], 160);
    check("line0_hblank_dots", ms[0], 216);
    check("ls_first", ls_first, 456);
    check("ls_period_bad", ls_bad, 0);
    check("ls_count", ls_n, 154);
    check("vb_count", vb_n, 1);
    check("vb_ce", vb_c, 65664);
    check("vb_ly", vb_ly, 144);
    check("vb_dot", vb_dot, 0);
    check("vb_mode", vb_mode, 1);
    check("frame_pre_ly", ly_pre, 153);
    check("frame_pre_mode", mode_pre, 1);
    check("frame_wrap_ly", ly_end, 0);
    check("frame_wrap_dot", dot_end, 0);
    check("frame_wrap_mode", mode_end, 2);
    check("stat_frame_count", st_n, 145);
    check("stat_frame_start", st_last, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
